// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard / forwarding unit.
//   state_e     : load-use stall FSM states
//   SEL_REGFILE : forward-select code meaning "read from register file"
//   sel_width   : width of a forward select able to name buffers 1..n plus 0
package hazard_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   localparam int SEL_REGFILE = 0;

   function automatic int sel_width(input int num_stages);
      return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one ALU operand.
// Ports:
//   src_i       : operand register address
//   used_i      : operand is actually read
//   stage_wb_i  : per-buffer write-back enable (bit k-1 = buffer k)
//   stage_dst_i : per-buffer destination (slice k-1 = buffer k)
//   sel_o       : 0 = register file, k = youngest matching buffer k
//   hit1_o      : operand matches buffer 1 (youngest)
module fwd_match
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 3,
   parameter int NUM_STAGES = 2,
   parameter int ZERO_REG   = 1,
   localparam int SEL_W     = sel_width(NUM_STAGES)
) (
   input  logic [REG_ADDR_W-1:0]            src_i,
   input  logic                             used_i,
   input  logic [NUM_STAGES-1:0]            stage_wb_i,
   input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_dst_i,
   output logic [SEL_W-1:0]                 sel_o,
   output logic                             hit1_o
);

   logic                  src_live;
   logic [NUM_STAGES-1:0] hit;

   // A hard-wired zero register is never produced by any buffer.
   assign src_live = used_i && !((ZERO_REG != 0) && (src_i == '0));

   always_comb begin
      hit = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         hit[k] = src_live && stage_wb_i[k] &&
                  (stage_dst_i[k*REG_ADDR_W +: REG_ADDR_W] == src_i);
      end
   end

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      sel_o = SEL_W'(SEL_REGFILE);
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (hit[k]) begin
            sel_o = SEL_W'(k + 1);
         end
      end
   end

   assign hit1_o = hit[0];

endmodule

// File: rtl/hazard_forward_unit.sv
// Data-hazard unit: operand forwarding selects plus load-use stall control.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_valid                 : decode-stage instruction present
//   id_src1/2, id_src1/2_used: operand addresses and read enables
//   stage_wb/load/dst        : downstream buffer info (buffer 1 = youngest)
//   flush                    : squash decode instruction, abort any stall
//   stall                    : hold PC and decode (combinational)
//   ex_bubble                : execute stage holds a bubble (registered)
//   fwd_sel1/2               : ALU operand source, 0 = regfile (registered)
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal flow; a load-use hazard stalls this same cycle
// STALL | holding decode for the remaining load-latency cycles
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W   = 3,
   parameter int NUM_STAGES   = 2,
   parameter int LOAD_LATENCY = 1,
   parameter int ZERO_REG     = 1,
   localparam int SEL_W       = sel_width(NUM_STAGES)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             id_valid,
   input  logic [REG_ADDR_W-1:0]            id_src1,
   input  logic [REG_ADDR_W-1:0]            id_src2,
   input  logic                             id_src1_used,
   input  logic                             id_src2_used,
   input  logic [NUM_STAGES-1:0]            stage_wb,
   input  logic [NUM_STAGES-1:0]            stage_load,
   input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_dst,
   input  logic                             flush,
   output logic                             stall,
   output logic                             ex_bubble,
   output logic [SEL_W-1:0]                 fwd_sel1,
   output logic [SEL_W-1:0]                 fwd_sel2
);

   localparam logic [2:0] LAT_M1 = 3'(LOAD_LATENCY - 1);

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] sel1_c, sel2_c;
   logic             hit1_a, hit1_b;
   logic             hazard;
   logic             ex_bubble_q;
   logic [SEL_W-1:0] fwd_sel1_q, fwd_sel2_q;
   logic             unused_stage_load;

   // Only buffer 1 can cause a load-use stall; older loads forward normally.
   assign unused_stage_load = ^stage_load;

   fwd_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_STAGES (NUM_STAGES),
      .ZERO_REG   (ZERO_REG)
   ) u_match_src1 (
      .src_i       (id_src1),
      .used_i      (id_src1_used),
      .stage_wb_i  (stage_wb),
      .stage_dst_i (stage_dst),
      .sel_o       (sel1_c),
      .hit1_o      (hit1_a)
   );

   fwd_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_STAGES (NUM_STAGES),
      .ZERO_REG   (ZERO_REG)
   ) u_match_src2 (
      .src_i       (id_src2),
      .used_i      (id_src2_used),
      .stage_wb_i  (stage_wb),
      .stage_dst_i (stage_dst),
      .sel_o       (sel2_c),
      .hit1_o      (hit1_b)
   );

   // Decode inputs are only evaluated in RUN.
   assign hazard = (state_q == RUN) && id_valid && !flush &&
                   stage_load[0] && (hit1_a || hit1_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The RUN cycle that detects the hazard is itself the first stall cycle,
   // so STALL covers LOAD_LATENCY-1 further cycles: it leaves on the edge
   // where the counter decrements to zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = RUN;
         cnt_d   = 3'd0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (hazard && (LAT_M1 != 3'd0)) begin
                  state_d = STALL;
                  cnt_d   = LAT_M1;
               end else begin
                  cnt_d   = 3'd0;
               end
            end
            STALL: begin
               if (cnt_q <= 3'd1) begin
                  state_d = RUN;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d   = cnt_q - 3'd1;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   always_comb begin
      stall = 1'b0;
      if (!flush) begin
         stall = (state_q == STALL) || hazard;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || stall || flush || !id_valid) begin
         fwd_sel1_q  <= SEL_W'(SEL_REGFILE);
         fwd_sel2_q  <= SEL_W'(SEL_REGFILE);
         ex_bubble_q <= 1'b1;
      end else begin
         fwd_sel1_q  <= sel1_c;
         fwd_sel2_q  <= sel2_c;
         ex_bubble_q <= 1'b0;
      end
   end

   assign fwd_sel1  = fwd_sel1_q;
   assign fwd_sel2  = fwd_sel2_q;
   assign ex_bubble = ex_bubble_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

   localparam int RW = 3;
   localparam int NS = 2;
   localparam int LL = 3;
   localparam int ZR = 1;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid;
   logic [RW-1:0]   id_src1, id_src2;
   logic            id_src1_used, id_src2_used;
   logic [NS-1:0]   stage_wb, stage_load;
   logic [NS*RW-1:0] stage_dst;
   logic            flush;
   logic            stall, ex_bubble;
   logic [SW-1:0]   fwd_sel1, fwd_sel2;

   always #5 clk = ~clk;

   hazard_forward_unit #(
      .REG_ADDR_W   (RW),
      .NUM_STAGES   (NS),
      .LOAD_LATENCY (LL),
      .ZERO_REG     (ZR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_src1_used (id_src1_used),
      .id_src2_used (id_src2_used),
      .stage_wb     (stage_wb),
      .stage_load   (stage_load),
      .stage_dst    (stage_dst),
      .flush        (flush),
      .stall        (stall),
      .ex_bubble    (ex_bubble),
      .fwd_sel1     (fwd_sel1),
      .fwd_sel2     (fwd_sel2)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: remaining stall cycles as a plain integer,
   // youngest-match search over the buffers.
   int rem    = 0;
   bit mvalid = 1'b0;
   int es1, es2, eb;

   function automatic int dst_of(input int k);
      return int'(stage_dst[(k-1)*RW +: RW]);
   endfunction

   function automatic int model_sel(input logic [RW-1:0] s, input logic u);
      if (!u) return 0;
      if (ZR != 0 && s == 0) return 0;
      for (int k = 1; k <= NS; k++) begin
         if (stage_wb[k-1] && dst_of(k) == int'(s)) return k;
      end
      return 0;
   endfunction

   function automatic bit model_hz();
      return rem == 0 && id_valid && !flush && stage_load[0] &&
             (model_sel(id_src1, id_src1_used) == 1 ||
              model_sel(id_src2, id_src2_used) == 1);
   endfunction

   function automatic bit model_stall();
      return (rem > 0 && !flush) || model_hz();
   endfunction

   always @(posedge clk) begin
      bit st, hz;
      hz = model_hz();
      st = model_stall();
      if (rst) begin
         rem    = 0;
         es1    = 0;
         es2    = 0;
         eb     = 1;
         mvalid = 1'b1;
      end else begin
         if (st || flush || !id_valid) begin
            es1 = 0;
            es2 = 0;
            eb  = 1;
         end else begin
            es1 = model_sel(id_src1, id_src1_used);
            es2 = model_sel(id_src2, id_src2_used);
            eb  = 0;
         end
         if (flush)        rem = 0;
         else if (rem > 0) rem = rem - 1;
         else if (hz)      rem = LL - 1;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         check("model_stall", 32'(stall), 32'(model_stall()));
         check("model_bubble", 32'(ex_bubble), 32'(eb));
         check("model_sel1", 32'(fwd_sel1), 32'(es1));
         check("model_sel2", 32'(fwd_sel2), 32'(es2));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // d2 = buffer 2 destination, d1 = buffer 1 destination
   task automatic set_stage(input logic [1:0] wb, input logic [1:0] ld,
                            input logic [2:0] d2, input logic [2:0] d1);
      stage_wb   = wb;
      stage_load = ld;
      stage_dst  = {d2, d1};
   endtask

   task automatic set_dec(input logic v, input logic [2:0] s1, input logic u1,
                          input logic [2:0] s2, input logic u2);
      id_valid     = v;
      id_src1      = s1;
      id_src1_used = u1;
      id_src2      = s2;
      id_src2_used = u2;
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      set_stage(2'b00, 2'b00, 3'd0, 3'd0);
      set_dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      check("rst_sel1", 32'(fwd_sel1), 0);
      check("rst_sel2", 32'(fwd_sel2), 0);
      check("rst_bubble", 32'(ex_bubble), 1);
      check("rst_stall", 32'(stall), 0);
      tick();

      // youngest of two matching buffers wins
      set_stage(2'b11, 2'b00, 3'd3, 3'd3);
      set_dec(1'b1, 3'd3, 1'b1, 3'd0, 1'b0);
      #1 check("fwd_stall", 32'(stall), 0);
      tick();
      check("fwd_sel1", 32'(fwd_sel1), 1);
      check("fwd_sel2", 32'(fwd_sel2), 0);
      check("fwd_bubble", 32'(ex_bubble), 0);

      // only the older buffer writes
      set_stage(2'b10, 2'b00, 3'd5, 3'd5);
      set_dec(1'b1, 3'd3, 1'b1, 3'd5, 1'b1);
      tick();
      check("old_sel2", 32'(fwd_sel2), 2);
      check("old_sel1", 32'(fwd_sel1), 0);

      // zero register never forwards nor stalls, even behind a load
      set_stage(2'b01, 2'b01, 3'd0, 3'd0);
      set_dec(1'b1, 3'd0, 1'b1, 3'd0, 1'b0);
      #1 check("zero_stall", 32'(stall), 0);
      tick();
      check("zero_sel1", 32'(fwd_sel1), 0);

      // unused source
      set_stage(2'b01, 2'b01, 3'd0, 3'd2);
      set_dec(1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
      #1 check("unused_stall", 32'(stall), 0);
      tick();
      check("unused_sel1", 32'(fwd_sel1), 0);

      // no valid instruction
      set_stage(2'b11, 2'b00, 3'd3, 3'd3);
      set_dec(1'b0, 3'd3, 1'b1, 3'd3, 1'b1);
      tick();
      check("invalid_bubble", 32'(ex_bubble), 1);
      check("invalid_sel1", 32'(fwd_sel1), 0);

      // flush masks a hazard in RUN
      set_stage(2'b01, 2'b01, 3'd0, 3'd4);
      set_dec(1'b1, 3'd4, 1'b1, 3'd0, 1'b0);
      flush = 1'b1;
      #1 check("flush_run_stall", 32'(stall), 0);
      tick();
      flush = 1'b0;
      check("flush_run_bubble", 32'(ex_bubble), 1);
      set_stage(2'b00, 2'b00, 3'd0, 3'd0);
      tick();

      // load-use on src1: exactly three stall cycles
      set_stage(2'b01, 2'b01, 3'd0, 3'd4);
      set_dec(1'b1, 3'd4, 1'b1, 3'd0, 1'b0);
      #1 check("lu_stall0", 32'(stall), 1);
      tick();
      check("lu_bubble0", 32'(ex_bubble), 1);
      set_stage(2'b10, 2'b10, 3'd4, 3'd0);
      set_dec(1'b1, 3'd4, 1'b1, 3'd4, 1'b1);
      #1 check("lu_stall1", 32'(stall), 1);
      tick();
      check("lu_bubble1", 32'(ex_bubble), 1);
      #1 check("lu_stall2", 32'(stall), 1);
      tick();
      check("lu_bubble2", 32'(ex_bubble), 1);
      #1 check("lu_stall3", 32'(stall), 0);
      tick();
      check("lu_sel1", 32'(fwd_sel1), 2);
      check("lu_sel2", 32'(fwd_sel2), 2);
      check("lu_bubble3", 32'(ex_bubble), 0);

      // load-use via src2, cleared by flush
      set_stage(2'b01, 2'b01, 3'd0, 3'd6);
      set_dec(1'b1, 3'd0, 1'b0, 3'd6, 1'b1);
      #1 check("lu2_stall", 32'(stall), 1);
      tick();
      flush = 1'b1;
      set_stage(2'b00, 2'b00, 3'd0, 3'd0);
      tick();
      flush = 1'b0;
      tick();

      // flush in the second stall cycle
      set_stage(2'b01, 2'b01, 3'd0, 3'd4);
      set_dec(1'b1, 3'd4, 1'b1, 3'd0, 1'b0);
      tick();
      set_stage(2'b10, 2'b10, 3'd4, 3'd0);
      flush = 1'b1;
      #1 check("flush_stall", 32'(stall), 0);
      tick();
      flush = 1'b0;
      check("flush_bubble", 32'(ex_bubble), 1);
      #1 check("flush_after_stall", 32'(stall), 0);
      tick();
      check("flush_sel1", 32'(fwd_sel1), 2);

      // reset in the first STALL cycle
      set_stage(2'b01, 2'b01, 3'd0, 3'd4);
      set_dec(1'b1, 3'd4, 1'b1, 3'd0, 1'b0);
      tick();
      rst = 1'b1;
      set_stage(2'b10, 2'b10, 3'd4, 3'd0);
      tick();
      rst = 1'b0;
      #1 check("rstmid_stall", 32'(stall), 0);
      check("rstmid_sel1", 32'(fwd_sel1), 0);
      check("rstmid_sel2", 32'(fwd_sel2), 0);
      check("rstmid_bubble", 32'(ex_bubble), 1);
      tick();
      check("rstmid_resume_sel1", 32'(fwd_sel1), 2);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
